// File: rtl/axil_ram_mp.sv
// ---------------------------------------------------------------------------
// axil_ram_mp
//   Shared scratchpad / mailbox RAM with PORTS independent AXI4-Lite slave
//   ports. All ports share one single-ported word array; a round-robin
//   arbiter over 2*PORTS requesters (write p at 2p, read p at 2p+1) grants at
//   most one access per clock.
//
// Ports (per-port buses are packed, port p at [p*W +: W]):
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axil_aw*        write address channel   (awaddr, awvalid, awready)
//   s_axil_w*         write data channel      (wdata, wstrb, wvalid, wready)
//   s_axil_b*         write response channel  (bresp, bvalid, bready)
//   s_axil_ar*        read address channel    (araddr, arvalid, arready)
//   s_axil_r*         read data channel       (rdata, rresp, rvalid, rready)
//
// Read latency from the AR handshake to rvalid is 1 cycle, or 2 cycles when
// PIPELINE_OUTPUT=1. Responses are always OKAY. The array is not reset.
// ---------------------------------------------------------------------------
module axil_ram_mp #(
  parameter int PORTS           = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [PORTS*ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [PORTS-1:0]              s_axil_awvalid,
  output logic [PORTS-1:0]              s_axil_awready,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [PORTS*STRB_WIDTH-1:0]   s_axil_wstrb,
  input  logic [PORTS-1:0]              s_axil_wvalid,
  output logic [PORTS-1:0]              s_axil_wready,
  output logic [PORTS*2-1:0]            s_axil_bresp,
  output logic [PORTS-1:0]              s_axil_bvalid,
  input  logic [PORTS-1:0]              s_axil_bready,

  input  logic [PORTS*ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [PORTS-1:0]              s_axil_arvalid,
  output logic [PORTS-1:0]              s_axil_arready,
  output logic [PORTS*DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [PORTS*2-1:0]            s_axil_rresp,
  output logic [PORTS-1:0]              s_axil_rvalid,
  input  logic [PORTS-1:0]              s_axil_rready
);

  localparam int REQS   = 2 * PORTS;
  localparam int PTR_W  = $clog2(REQS);
  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int OFF    = $clog2(STRB_WIDTH);
  localparam int WORD_W = ADDR_WIDTH - OFF;
  localparam int WORDS  = 1 << WORD_W;

  logic [DATA_WIDTH-1:0]       mem [WORDS];

  logic [PTR_W-1:0]            rr_ptr;      // first requester examined this cycle
  logic [REQS-1:0]             req;
  logic [PTR_W-1:0]            cand;
  logic                        gnt_vld;
  logic [PTR_W-1:0]            gnt_idx;
  logic [PORT_W-1:0]           gnt_port;
  logic                        wr_en;
  logic                        rd_en;

  logic [ADDR_WIDTH-1:0]       waddr_sel;
  logic [ADDR_WIDTH-1:0]       raddr_sel;
  logic [DATA_WIDTH-1:0]       wdata_sel;
  logic [STRB_WIDTH-1:0]       wstrb_sel;
  logic [WORD_W-1:0]           widx;
  logic [WORD_W-1:0]           ridx;

  logic [PORTS-1:0]            bvalid_q;
  logic [PORTS-1:0]            rvalid_q;
  logic [PORTS-1:0]            rd_pend_q;   // read granted, data still in stage register
  logic [PORTS*DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0]       stage_data;
  logic                        stage_vld;
  logic [PORT_W-1:0]           stage_port;

  logic                        unused_addr_bits;

  // -------------------------------------------------------------------------
  // Request vector. A write needs both AW and W present and a free (or
  // draining) B slot; a read needs a free (or draining) R slot. In the
  // pipelined variant a read sitting in the stage register also blocks, which
  // keeps one read outstanding per port.
  // -------------------------------------------------------------------------
  always_comb begin
    req = '0;
    for (int p = 0; p < PORTS; p++) begin
      req[2*p]   = s_axil_awvalid[p] & s_axil_wvalid[p] &
                   (~bvalid_q[p] | s_axil_bready[p]);
      req[2*p+1] = s_axil_arvalid[p] & ~rd_pend_q[p] &
                   (~rvalid_q[p] | s_axil_rready[p]);
    end
  end

  // Round-robin: scan from rr_ptr upward with wrap, first requester wins.
  // Grants are suppressed while in reset so no ready can pulse there.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < REQS; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % REQS);
      if (!gnt_vld && rst_n && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_port = PORT_W'(gnt_idx >> 1);
  assign wr_en    = gnt_vld & ~gnt_idx[0];
  assign rd_en    = gnt_vld &  gnt_idx[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == PTR_W'(REQS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake outputs: AW and W are accepted together, only on a grant.
  // -------------------------------------------------------------------------
  always_comb begin
    s_axil_awready = '0;
    s_axil_arready = '0;
    if (wr_en) s_axil_awready[gnt_port] = 1'b1;
    if (rd_en) s_axil_arready[gnt_port] = 1'b1;
  end

  assign s_axil_wready = s_axil_awready;
  assign s_axil_bresp  = '0;
  assign s_axil_rresp  = '0;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;

  // -------------------------------------------------------------------------
  // Memory access for the granted port. Low address bits below the word
  // size are ignored.
  // -------------------------------------------------------------------------
  assign waddr_sel = s_axil_awaddr[gnt_port*ADDR_WIDTH +: ADDR_WIDTH];
  assign raddr_sel = s_axil_araddr[gnt_port*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_sel = s_axil_wdata[gnt_port*DATA_WIDTH +: DATA_WIDTH];
  assign wstrb_sel = s_axil_wstrb[gnt_port*STRB_WIDTH +: STRB_WIDTH];
  assign widx      = waddr_sel[ADDR_WIDTH-1:OFF];
  assign ridx      = raddr_sel[ADDR_WIDTH-1:OFF];

  assign unused_addr_bits = ^{waddr_sel, raddr_sel};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_sel[b]) mem[widx][b*8 +: 8] <= wdata_sel[b*8 +: 8];
      end
    end
    if (rd_en) stage_data <= mem[ridx];
  end

  // -------------------------------------------------------------------------
  // Per-port response state. rdata only changes when a new read result
  // lands, which can only happen after the previous beat was taken, so it
  // holds stable while rvalid & !rready.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q   <= '0;
      rvalid_q   <= '0;
      rd_pend_q  <= '0;
      rdata_q    <= '0;
      stage_vld  <= 1'b0;
      stage_port <= '0;
    end else begin
      stage_vld  <= rd_en;
      stage_port <= gnt_port;
      for (int p = 0; p < PORTS; p++) begin
        if (wr_en && gnt_port == PORT_W'(p)) begin
          bvalid_q[p] <= 1'b1;
        end else if (s_axil_bready[p]) begin
          bvalid_q[p] <= 1'b0;
        end

        if (PIPELINE_OUTPUT == 0) begin
          rd_pend_q[p] <= 1'b0;
          if (rd_en && gnt_port == PORT_W'(p)) begin
            rvalid_q[p]                      <= 1'b1;
            rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= mem[ridx];
          end else if (s_axil_rready[p]) begin
            rvalid_q[p] <= 1'b0;
          end
        end else begin
          if (rd_en && gnt_port == PORT_W'(p)) begin
            rd_pend_q[p] <= 1'b1;
          end
          if (stage_vld && stage_port == PORT_W'(p)) begin
            rd_pend_q[p]                     <= 1'b0;
            rvalid_q[p]                      <= 1'b1;
            rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= stage_data;
          end else if (s_axil_rready[p]) begin
            rvalid_q[p] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_axil_ram_mp
//   Bench for axil_ram_mp: a 2-port unpipelined instance driven by directed
//   and random traffic and compared cycle by cycle against a reference model
//   (word array, round-robin rule, response flags), plus a 1-port
//   PIPELINE_OUTPUT=1 instance for the read latency check.
// ---------------------------------------------------------------------------
module tb_axil_ram_mp;

  localparam int P  = 2;
  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P*AW-1:0] awaddr, araddr;
  logic [P*DW-1:0] wdata, rdata;
  logic [P*4-1:0]  wstrb;
  logic [P*2-1:0]  bresp, rresp;
  logic [P-1:0]    awvalid, awready, wvalid, wready, bvalid, bready;
  logic [P-1:0]    arvalid, arready, rvalid, rready;

  logic [15:0] d2_awaddr, d2_araddr;
  logic [31:0] d2_wdata, d2_rdata;
  logic [3:0]  d2_wstrb;
  logic [1:0]  d2_bresp, d2_rresp;
  logic [0:0]  d2_awvalid, d2_awready, d2_wvalid, d2_wready, d2_bvalid, d2_bready;
  logic [0:0]  d2_arvalid, d2_arready, d2_rvalid, d2_rready;

  axil_ram_mp #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPELINE_OUTPUT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  axil_ram_mp #(.PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(16), .PIPELINE_OUTPUT(1)) dut_pipe (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(d2_awaddr), .s_axil_awvalid(d2_awvalid), .s_axil_awready(d2_awready),
    .s_axil_wdata(d2_wdata), .s_axil_wstrb(d2_wstrb), .s_axil_wvalid(d2_wvalid), .s_axil_wready(d2_wready),
    .s_axil_bresp(d2_bresp), .s_axil_bvalid(d2_bvalid), .s_axil_bready(d2_bready),
    .s_axil_araddr(d2_araddr), .s_axil_arvalid(d2_arvalid), .s_axil_arready(d2_arready),
    .s_axil_rdata(d2_rdata), .s_axil_rresp(d2_rresp), .s_axil_rvalid(d2_rvalid), .s_axil_rready(d2_rready)
  );

  // reference model state
  logic [31:0] m_mem [16];
  logic [P-1:0] m_bv, m_rv;
  logic [31:0] m_rd [P];
  int          m_next;
  int          pend_wk [P];
  int          pend_rk [P];
  logic [31:0] pend_wd [P];
  logic [3:0]  pend_ws [P];
  bit          keep_busy;
  int          gcnt [4];
  int          n_vec, n_err;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 16 model slots: low words 0..7 and the top 8 words of the address space
  function automatic logic [15:0] word_of(input int k);
    return (k < 8) ? 16'(k) : 16'(16'h3FF0 + k);
  endfunction

  task automatic set_write(input int p, input int k, input logic [31:0] d, input logic [3:0] s);
    awaddr[p*AW +: AW] = (word_of(k) << 2) | 16'($urandom % 4);
    wdata[p*DW +: DW]  = d;
    wstrb[p*4 +: 4]    = s;
    awvalid[p] = 1'b1;
    wvalid[p]  = 1'b1;
    pend_wk[p] = k;
    pend_wd[p] = d;
    pend_ws[p] = s;
  endtask

  task automatic set_read(input int p, input int k);
    araddr[p*AW +: AW] = (word_of(k) << 2) | 16'($urandom % 4);
    arvalid[p] = 1'b1;
    pend_rk[p] = k;
  endtask

  // One clock: check DUT against the model at the falling edge, advance the
  // model to the next rising edge, then retire accepted requests.
  task automatic step();
    logic [3:0]   rq;
    logic [P-1:0] eaw, ear;
    int           g, idx;
    @(negedge clk);
    chk_val("bvalid", 64'(bvalid), 64'(m_bv));
    chk_val("rvalid", 64'(rvalid), 64'(m_rv));
    for (int p = 0; p < P; p++) chk_val("rdata", 64'(rdata[p*DW +: DW]), 64'(m_rd[p]));
    chk_val("resp", 64'({bresp, rresp}), 64'd0);
    for (int p = 0; p < P; p++) begin
      rq[2*p]   = awvalid[p] & wvalid[p] & (~m_bv[p] | bready[p]);
      rq[2*p+1] = arvalid[p] & (~m_rv[p] | rready[p]);
    end
    g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_next + k) % 4;
      if (g < 0 && rq[idx]) g = idx;
    end
    eaw = '0;
    ear = '0;
    if (g >= 0) begin
      if (g % 2 == 0) eaw[g/2] = 1'b1;
      else            ear[g/2] = 1'b1;
    end
    chk_val("awready", 64'(awready), 64'(eaw));
    chk_val("wready",  64'(wready),  64'(eaw));
    chk_val("arready", 64'(arready), 64'(ear));
    for (int p = 0; p < P; p++) begin
      if (awready[p]) gcnt[2*p]++;
      if (arready[p]) gcnt[2*p+1]++;
    end
    for (int p = 0; p < P; p++) begin
      if (eaw[p]) begin
        m_bv[p] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (pend_ws[p][b]) m_mem[pend_wk[p]][b*8 +: 8] = pend_wd[p][b*8 +: 8];
      end else if (bready[p]) begin
        m_bv[p] = 1'b0;
      end
      if (ear[p]) begin
        m_rv[p] = 1'b1;
        m_rd[p] = m_mem[pend_rk[p]];
      end else if (rready[p]) begin
        m_rv[p] = 1'b0;
      end
    end
    if (g >= 0) m_next = (g + 1) % 4;
    @(posedge clk);
    #1;
    if (!keep_busy) begin
      for (int p = 0; p < P; p++) begin
        if (eaw[p]) begin awvalid[p] = 1'b0; wvalid[p] = 1'b0; end
        if (ear[p]) arvalid[p] = 1'b0;
      end
    end
  endtask

  task automatic run_until_idle(input int maxc);
    int c;
    c = 0;
    while ((awvalid != '0 || arvalid != '0) && c < maxc) begin
      step();
      c++;
    end
    if (c >= maxc) chk_val("idle_timeout", 64'({awvalid, arvalid}), 64'd0);
    step();
    step();
  endtask

  task automatic model_reset();
    m_bv   = '0;
    m_rv   = '0;
    m_next = 0;
    for (int p = 0; p < P; p++) m_rd[p] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] d;
    n_vec = 0; n_err = 0; keep_busy = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = '1; rready = '1;
    d2_awaddr = '0; d2_araddr = '0; d2_wdata = '0; d2_wstrb = 4'hF;
    d2_awvalid = '0; d2_wvalid = '0; d2_arvalid = '0; d2_bready = 1'b1; d2_rready = 1'b1;
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    model_reset();

    // reset state, with test-1 requests already presented
    set_write(0, 0, 32'h11223344, 4'hF);
    set_read(1, 0);
    #3;
    chk_val("rst_ready", 64'({awready, wready, arready}), 64'd0);
    chk_val("rst_valid", 64'({bvalid, rvalid}), 64'd0);
    chk_val("rst_rdata", 64'(rdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: write from p0 then read of same word from p1
    run_until_idle(10);
    chk_val("t1_rdata", 64'(rdata[DW +: DW]), 64'h11223344);

    // 2: byte strobes
    set_write(0, 4, 32'hAABBCCDD, 4'hF);
    run_until_idle(10);
    set_write(0, 4, 32'h00000099, 4'h1);
    run_until_idle(10);
    set_read(1, 4);
    run_until_idle(10);
    chk_val("t2_rdata", 64'(rdata[DW +: DW]), 64'hAABBCC99);

    // fill the remaining model slots so later reads hit known data
    for (int k = 1; k < 16; k++) begin
      if (k != 4) begin
        set_write(0, k, $urandom, 4'hF);
        run_until_idle(10);
      end
    end

    // 5: pipelined instance, AR handshake at N -> rvalid at N+2
    d2_awaddr = 16'h0020; d2_wdata = 32'hCAFEF00D;
    d2_awvalid = 1'b1; d2_wvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!d2_awready[0] && c < 10);
    chk_val("t5_aw_hs", 64'(d2_awready), 64'd1);
    @(posedge clk); #1;
    d2_awvalid = 1'b0; d2_wvalid = 1'b0;
    d2_araddr = 16'h0023; d2_arvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!d2_arready[0] && c < 10);
    chk_val("t5_ar_hs", 64'(d2_arready), 64'd1);
    @(posedge clk); #1;
    d2_arvalid = 1'b0;
    @(negedge clk);
    chk_val("t5_rvalid_n1", 64'(d2_rvalid), 64'd0);
    @(negedge clk);
    chk_val("t5_rvalid_n2", 64'(d2_rvalid), 64'd1);
    chk_val("t5_rdata", 64'(d2_rdata), 64'hCAFEF00D);
    @(posedge clk); #1;

    // 3: all four requesters busy, each served twice in 8 cycles
    keep_busy = 1;
    set_write(0, 1, $urandom, 4'hF);
    set_read(0, 2);
    set_write(1, 3, $urandom, 4'hF);
    set_read(1, 9);
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    repeat (8) step();
    keep_busy = 0;
    for (int i = 0; i < 4; i++) chk_val($sformatf("t3_grants_%0d", i), 64'(gcnt[i]), 64'd2);
    run_until_idle(20);

    // 4: p0 B backpressure; p1 continues; p1 R held under rready=0
    bready[0] = 1'b0;
    set_write(0, 7, $urandom, 4'hF);
    run_until_idle(10);
    set_write(0, 8, $urandom, 4'hF);
    rready[1] = 1'b0;
    set_read(1, 7);
    set_write(1, 10, $urandom, 4'hF);
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    repeat (10) step();
    chk_val("t4_p0_blocked", 64'(gcnt[0]), 64'd0);
    chk_val("t4_bvalid0", 64'(bvalid[0]), 64'd1);
    chk_val("t4_p1_write", 64'(gcnt[2]), 64'd1);
    chk_val("t4_p1_read", 64'(gcnt[3]), 64'd1);
    chk_val("t4_rdata_hold", 64'(rdata[DW +: DW]), 64'(m_mem[7]));
    bready = '1;
    rready = '1;
    run_until_idle(20);

    // random traffic with random ready backpressure
    repeat (300) begin
      for (int p = 0; p < P; p++) begin
        bready[p] = ($urandom % 4) != 0;
        rready[p] = ($urandom % 4) != 0;
        if (!awvalid[p] && ($urandom % 2) == 1) set_write(p, int'($urandom % 16), $urandom, 4'($urandom));
        if (!arvalid[p] && ($urandom % 2) == 1) set_read(p, int'($urandom % 16));
      end
      step();
    end
    bready = '1;
    rready = '1;
    run_until_idle(50);

    // 6: reset with B and R pending, then data survives
    bready = '0;
    rready = '0;
    d = 32'h5A5A0F0F;
    set_write(0, 5, d, 4'hF);
    set_read(1, 6);
    repeat (3) step();
    chk_val("t6_pending", 64'({bvalid[0], rvalid[1]}), 64'd3);
    set_write(1, 11, $urandom, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk_val("t6_ready", 64'({awready, wready, arready}), 64'd0);
    chk_val("t6_valid", 64'({bvalid, rvalid}), 64'd0);
    chk_val("t6_rdata", 64'(rdata), 64'd0);
    awvalid = '0; wvalid = '0; arvalid = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bready = '1;
    rready = '1;
    set_read(0, 5);
    run_until_idle(10);
    chk_val("t6_persist", 64'(rdata[0 +: DW]), 64'(d));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
